// File: rtl/hash_blacklist_if.sv
// hash_blacklist_if: insert, check and response channels of the hash blacklist,
// plus the occupancy status (count/full) reported back to the requester.
interface hash_blacklist_if #(
  parameter int HASH_SIZE = 32,
  parameter int DEPTH     = 16
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                 ins_valid;
  logic                 ins_ready;
  logic [HASH_SIZE-1:0] ins_hash;

  logic                 chk_valid;
  logic                 chk_ready;
  logic [HASH_SIZE-1:0] chk_hash;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_hit;
  logic [IDX_W-1:0]     rsp_idx;

  logic [CNT_W-1:0]     count;
  logic                 full;

  modport master (
    output ins_valid, ins_hash, chk_valid, chk_hash, rsp_ready,
    input  ins_ready, chk_ready, rsp_valid, rsp_hit, rsp_idx, count, full
  );

  modport slave (
    input  ins_valid, ins_hash, chk_valid, chk_hash, rsp_ready,
    output ins_ready, chk_ready, rsp_valid, rsp_hit, rsp_idx, count, full
  );
endinterface

// File: rtl/hash_blacklist.sv
// hash_blacklist: ring of DEPTH stored hashes (oldest overwritten when full)
// answering membership lookups. By default a lookup walks the valid entries
// with a single comparator; defining HASH_BL_PARALLEL_EN compares every entry
// in the accept cycle instead and responds one cycle later.
module hash_blacklist #(
  parameter int HASH_SIZE = 32,
  parameter int DEPTH     = 16
) (
  input logic              clk,
  input logic              rst,
  hash_blacklist_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

`ifdef HASH_BL_PARALLEL_EN
  typedef enum logic [1:0] {IDLE, RESP} state_t;
`else
  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;
`endif

  state_t               r_state;
  logic [HASH_SIZE-1:0] r_entry [DEPTH];
  logic [DEPTH-1:0]     r_valid;
  logic [IDX_W-1:0]     r_wrPtr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_insReady;
  logic                 r_rspValid;
  logic                 r_rspHit;
  logic [IDX_W-1:0]     r_rspIdx;

  logic                 w_insFire;
  logic                 w_chkFire;

  // Inserts only land while idle, and an insert pre-empts a same-cycle check.
  assign w_insFire     = bus.ins_valid && r_insReady;
  assign bus.ins_ready = r_insReady;
  assign bus.chk_ready = r_insReady && !bus.ins_valid;
  assign w_chkFire     = bus.chk_valid && bus.chk_ready;

  assign bus.rsp_valid = r_rspValid;
  assign bus.rsp_hit   = r_rspHit;
  assign bus.rsp_idx   = r_rspIdx;
  assign bus.count     = r_count;
  assign bus.full      = (r_count == CNT_W'(DEPTH));

`ifdef HASH_BL_PARALLEL_EN
  logic             w_parHit;
  logic [IDX_W-1:0] w_parIdx;

  // Compare every entry at once; walking downwards leaves the lowest match.
  always_comb begin
    w_parHit = 1'b0;
    w_parIdx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_entry[i] == bus.chk_hash)) begin
        w_parHit = 1'b1;
        w_parIdx = IDX_W'(i);
      end
    end
  end
`else
  logic [HASH_SIZE-1:0] r_key;
  logic [IDX_W-1:0]     r_scanIdx;
  logic                 w_scanMatch;
  logic                 w_scanLast;

  assign w_scanMatch = r_valid[r_scanIdx] && (r_entry[r_scanIdx] == r_key);
  assign w_scanLast  = (CNT_W'(r_scanIdx) == (r_count - CNT_W'(1)));
`endif

  // Hash storage; stale data is harmless because validity is tracked separately.
  always_ff @(posedge clk) begin
    if (!rst && w_insFire) begin
      r_entry[r_wrPtr] <= bus.ins_hash;
    end
  end

  // Occupancy bookkeeping: valid bits, write pointer and saturating count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else if (w_insFire) begin
      r_valid[r_wrPtr] <= 1'b1;
      r_wrPtr          <= r_wrPtr + 1'b1;
      if (r_count != CNT_W'(DEPTH)) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  // Lookup sequencer with registered handshake and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_insReady <= 1'b1;
      r_rspValid <= 1'b0;
      r_rspHit   <= 1'b0;
      r_rspIdx   <= '0;
`ifndef HASH_BL_PARALLEL_EN
      r_key      <= '0;
      r_scanIdx  <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_chkFire) begin
            r_insReady <= 1'b0;
`ifdef HASH_BL_PARALLEL_EN
            r_state    <= RESP;
            r_rspValid <= 1'b1;
            r_rspHit   <= w_parHit;
            r_rspIdx   <= w_parIdx;
`else
            r_key     <= bus.chk_hash;
            r_scanIdx <= '0;
            if (r_count == '0) begin
              r_state    <= RESP;
              r_rspValid <= 1'b1;
              r_rspHit   <= 1'b0;
              r_rspIdx   <= '0;
            end else begin
              r_state <= SCAN;
            end
`endif
          end
        end
`ifndef HASH_BL_PARALLEL_EN
        SCAN: begin
          if (w_scanMatch) begin
            r_state    <= RESP;
            r_rspValid <= 1'b1;
            r_rspHit   <= 1'b1;
            r_rspIdx   <= r_scanIdx;
          end else if (w_scanLast) begin
            r_state    <= RESP;
            r_rspValid <= 1'b1;
            r_rspHit   <= 1'b0;
            r_rspIdx   <= '0;
          end else begin
            r_scanIdx <= r_scanIdx + 1'b1;
          end
        end
`endif
        RESP: begin
          if (bus.rsp_ready) begin
            r_state    <= IDLE;
            r_insReady <= 1'b1;
            r_rspValid <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_insReady <= 1'b1;
          r_rspValid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/hash_blacklist.md
# hash_blacklist

Stores hash values produced by the hash unit's insert path and answers lookups from its check path. It takes `bl_out` on insert and `hash` on check, and reports whether the checked value is already in the list. It holds up to DEPTH entries with oldest-first overwrite when full. Lookups use a sequential scan state machine with valid/ready handshakes on all three channels.

## Interface
- HASH_SIZE, 32, width of stored/compared hash values
- DEPTH, 16, number of entries; power of two, ≥ 2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ins_valid  in  1  insert request
- ins_ready  out  1  insert accepted when ins_valid && ins_ready
- ins_hash  in  HASH_SIZE  value to store (hash unit `bl_out`)
- chk_valid  in  1  check request
- chk_ready  out  1  check accepted when chk_valid && chk_ready
- chk_hash  in  HASH_SIZE  value to look up (hash unit `hash`)
- rsp_valid  out  1  lookup result valid
- rsp_ready  in  1  result consumed when rsp_valid && rsp_ready
- rsp_hit  out  1  1 = value present
- rsp_idx  out  $clog2(DEPTH)  matching entry index; 0 on miss
- count  out  $clog2(DEPTH+1)  number of valid entries
- full  out  1  count == DEPTH

## Operation
- Storage:
  - DEPTH entries, each with a valid bit.
  - wr_ptr selects the next entry to write and wraps DEPTH-1 → 0.
- Insert:
  - On accept, entry[wr_ptr] ← ins_hash and valid ← 1.
  - wr_ptr increments.
  - count increments, saturating at DEPTH.
  - When full, the insert overwrites the oldest entry; count stays at DEPTH.
  - Duplicates are not filtered.
- ins_ready = (state == IDLE). Inserts never alter the table during a scan.
- chk_ready = (state == IDLE) && !ins_valid. An insert wins over a simultaneous check; the check is accepted in a later cycle.
- State machine:
  - IDLE:
    - On check accept, latch chk_hash and set scan_idx ← 0.
    - If count == 0, go to RESP with miss; otherwise go to SCAN.
  - SCAN: each cycle compare entry[scan_idx] (valid only) against the latched value.
    - Match: go to RESP with hit, rsp_idx = scan_idx.
    - No match and scan_idx == count-1: go to RESP with miss. When full, all DEPTH entries are scanned.
    - Otherwise increment scan_idx.
  - RESP:
    - rsp_valid = 1; rsp_hit and rsp_idx are held stable.
    - On rsp_ready, go to IDLE.
- Entries are scanned in ascending index order, so a hit reports the lowest matching index.
- Reset at any point returns to IDLE and clears all valid bits, wr_ptr and count. An in-flight lookup is dropped with no response.

## Timing
- Reset values:
  - rsp_valid = 0, rsp_hit = 0, rsp_idx = 0
  - count = 0, full = 0
  - ins_ready = 1
  - chk_ready = !ins_valid
- Check accepted at edge N:
  - Hit at index k: rsp_valid high from cycle N+2+k.
  - Miss with c valid entries: rsp_valid high from cycle N+1+c. Empty table: N+1.
- rsp_valid stays high until the rsp_ready handshake. The next check can be accepted in the cycle after the handshake.
- Inserts update count and full on the edge after the accept.
- Insert back-to-back throughput is one per cycle while IDLE.

## Configuration
- HASH_BL_PARALLEL_EN defined:
  - SCAN state is removed; all DEPTH entries are compared in the accept cycle.
  - The lowest matching valid index is reported.
  - RESP is entered directly, so rsp_valid is high from cycle N+1 for both hit and miss.
- HASH_BL_PARALLEL_EN undefined: the sequential scan above applies, with one comparator.

## Test plan
- Reset, then check 0xDEADBEEF on the empty table:
  - Expect rsp_valid at N+1, rsp_hit = 0, rsp_idx = 0, count = 0.
- Insert 0x11, 0x22, 0x33, then check 0x33:
  - Expect hit, rsp_idx = 2, rsp_valid at N+4 (scan) or N+1 (parallel).
  - Check 0x44: expect miss at N+4.
- Insert 17 values 0..16 with DEPTH = 16:
  - Expect count = 16 and full = 1.
  - Entry 0 holds 16 and wr_ptr = 1.
  - Check 0 → miss; check 16 → hit at idx 0.
- Drive ins_valid and chk_valid together in IDLE:
  - Expect chk_ready = 0 and the insert stored.
  - The check is accepted the next cycle and sees the new entry.
- Hold rsp_ready = 0 for 5 cycles after a hit:
  - Expect rsp_valid, rsp_hit and rsp_idx stable.
  - ins_ready = 0 throughout.
  - Return to IDLE the cycle after rsp_ready rises.
- Assert rst mid-SCAN with 8 entries:
  - Expect no response, count = 0, and full = 0 the next cycle.
  - A following check of any previously inserted value misses.
